// File: rtl/fp_add_prep_pipe_if.sv
// Valid/ready bus between the operand source, the FP add preparer and the adder/normaliser.
// The slave modport is the preparer's view; the master modport is the producer/consumer side.
`timescale 1ns/1ps
interface fp_add_prep_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
);
  localparam int OP_W   = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = 2 * FRAC_W + 4;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op_1;
  logic [OP_W-1:0]   op_2;
  logic              op_sub;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic              nan_res;
  logic              inf_res;
  logic              legal;
  logic              res_sign;
  logic              eff_sub;
  logic [EXP_W-1:0]  exp_max;
  logic [MANT_W-1:0] mant_a;
  logic [MANT_W-1:0] mant_b;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, op_1, op_2, op_sub, in_tag, out_ready,
    output in_ready, out_valid, nan_res, inf_res, legal, res_sign,
           eff_sub, exp_max, mant_a, mant_b, out_tag
  );

  modport master (
    output in_valid, op_1, op_2, op_sub, in_tag, out_ready,
    input  in_ready, out_valid, nan_res, inf_res, legal, res_sign,
           eff_sub, exp_max, mant_a, mant_b, out_tag
  );
endinterface

// File: rtl/fp_add_prep_pipe.sv
// Two-stage FP adder operand preparer: stage 1 decodes, classifies and orders the operands,
// stage 2 aligns the smaller significand with a sticky bit and registers all results.
`timescale 1ns/1ps
module fp_add_prep_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  fp_add_prep_pipe_if.slave bus
);
  localparam int OP_W   = 1 + EXP_W + FRAC_W;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int MANT_W = 2 * FRAC_W + 4;

  // ---------------- handshake ----------------
  logic adv1, adv2, accept, in_ready_int;
  logic rdy_q, rdy_d;
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;

  // ---------------- per-operand decode ----------------
  logic [1:0][OP_W-1:0]   op_pk;
  logic [1:0][EXP_W-1:0]  ex_f;
  logic [1:0][EXP_W-1:0]  ex_e;
  logic [1:0][FRAC_W-1:0] fr_f;
  logic [1:0]             nan_f, inf_f, hid_f, zero_f;
  logic                   sign_1, sign_2e;

  assign op_pk   = {bus.op_2, bus.op_1};
  assign sign_1  = bus.op_1[OP_W-1];
  assign sign_2e = bus.op_2[OP_W-1] ^ bus.op_sub;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dec
    assign ex_f[gi]   = op_pk[gi][OP_W-2:FRAC_W];
    assign fr_f[gi]   = op_pk[gi][FRAC_W-1:0];
    assign hid_f[gi]  = (ex_f[gi] != '0);
    assign ex_e[gi]   = hid_f[gi] ? ex_f[gi] : EXP_W'(1);
    assign nan_f[gi]  = (&ex_f[gi]) & (|fr_f[gi]);
    assign inf_f[gi]  = (&ex_f[gi]) & ~(|fr_f[gi]);
    assign zero_f[gi] = ~hid_f[gi] & ~(|fr_f[gi]);
  end

  // ---------------- stage 1 combinational ----------------
  logic [EXP_W+FRAC_W-1:0] key_1, key_2;
  logic                    swap, tie;
  logic                    c_nan, c_inf, c_sign, c_eff_sub;
  logic [EXP_W-1:0]        c_exp, c_del;
  logic [SIG_W-1:0]        c_sig_a, c_sig_b;

  always_comb begin
    key_1     = {ex_e[0], fr_f[0]};
    key_2     = {ex_e[1], fr_f[1]};
    swap      = (key_2 > key_1);
    tie       = (key_2 == key_1);
    c_eff_sub = sign_1 ^ sign_2e;
    c_nan     = (|nan_f) | (&inf_f & c_eff_sub);
    c_inf     = ~c_nan & (|inf_f);
    c_sign    = 1'b0;
    c_exp     = '0;
    c_del     = '0;
    c_sig_a   = '0;
    c_sig_b   = '0;
    if (c_nan) begin
      c_sign = 1'b0;
    end else if (c_inf) begin
      c_sign = inf_f[0] ? sign_1 : sign_2e;
    end else begin
      // Exact cancellation gives +0; two zeros of one sign keep that sign.
      if (tie && c_eff_sub)
        c_sign = 1'b0;
      else if ((&zero_f) && !c_eff_sub)
        c_sign = sign_1;
      else
        c_sign = swap ? sign_2e : sign_1;
      if (swap) begin
        c_exp   = ex_e[1];
        c_del   = ex_e[1] - ex_e[0];
        c_sig_a = {hid_f[1], fr_f[1]};
        c_sig_b = {hid_f[0], fr_f[0]};
      end else begin
        c_exp   = ex_e[0];
        c_del   = ex_e[0] - ex_e[1];
        c_sig_a = {hid_f[0], fr_f[0]};
        c_sig_b = {hid_f[1], fr_f[1]};
      end
    end
  end

  // ---------------- stage 1 registers ----------------
  logic             s1_nan_q, s1_nan_d;
  logic             s1_inf_q, s1_inf_d;
  logic             s1_sign_q, s1_sign_d;
  logic             s1_eff_sub_q, s1_eff_sub_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [EXP_W-1:0] s1_del_q, s1_del_d;
  logic [SIG_W-1:0] s1_sig_a_q, s1_sig_a_d;
  logic [SIG_W-1:0] s1_sig_b_q, s1_sig_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // ---------------- stage 2 alignment ----------------
  logic [MANT_W-1:0] full_a, full_b, shift_b, lost_mask;
  logic [31:0]       del_ext;

  assign del_ext = 32'(s1_del_q);
  assign full_a  = {2'b00, s1_sig_a_q, {SIG_W{1'b0}}};
  assign full_b  = {2'b00, s1_sig_b_q, {SIG_W{1'b0}}};

  // Bit gi of B falls off the bottom whenever the shift distance exceeds gi.
  for (genvar gi = 0; gi < MANT_W; gi++) begin : g_lost
    assign lost_mask[gi] = (del_ext > 32'(gi));
  end

  always_comb begin
    shift_b = '0;
    if (del_ext >= 32'(MANT_W)) begin
      shift_b = {{(MANT_W-1){1'b0}}, |s1_sig_b_q};
    end else begin
      shift_b    = full_b >> del_ext;
      shift_b[0] = shift_b[0] | (|(full_b & lost_mask));
    end
  end

  // ---------------- stage 2 registers ----------------
  logic              o_nan_q, o_nan_d;
  logic              o_inf_q, o_inf_d;
  logic              o_legal_q, o_legal_d;
  logic              o_sign_q, o_sign_d;
  logic              o_eff_sub_q, o_eff_sub_d;
  logic [EXP_W-1:0]  o_exp_q, o_exp_d;
  logic [MANT_W-1:0] o_mant_a_q, o_mant_a_d;
  logic [MANT_W-1:0] o_mant_b_q, o_mant_b_d;
  logic [TAG_W-1:0]  o_tag_q, o_tag_d;

  assign adv2         = ~out_valid_q | bus.out_ready;
  assign adv1         = ~s1_valid_q | adv2;
  assign in_ready_int = rdy_q & adv1 & ~flush;
  assign accept       = bus.in_valid & in_ready_int;

  always_comb begin
    rdy_d        = 1'b1;
    s1_valid_d   = s1_valid_q;
    out_valid_d  = out_valid_q;
    s1_nan_d     = s1_nan_q;
    s1_inf_d     = s1_inf_q;
    s1_sign_d    = s1_sign_q;
    s1_eff_sub_d = s1_eff_sub_q;
    s1_exp_d     = s1_exp_q;
    s1_del_d     = s1_del_q;
    s1_sig_a_d   = s1_sig_a_q;
    s1_sig_b_d   = s1_sig_b_q;
    s1_tag_d     = s1_tag_q;
    o_nan_d      = o_nan_q;
    o_inf_d      = o_inf_q;
    o_legal_d    = o_legal_q;
    o_sign_d     = o_sign_q;
    o_eff_sub_d  = o_eff_sub_q;
    o_exp_d      = o_exp_q;
    o_mant_a_d   = o_mant_a_q;
    o_mant_b_d   = o_mant_b_q;
    o_tag_d      = o_tag_q;

    if (adv1) s1_valid_d = accept;
    if (adv2) out_valid_d = s1_valid_q;
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end

    if (accept) begin
      s1_nan_d     = c_nan;
      s1_inf_d     = c_inf;
      s1_sign_d    = c_sign;
      s1_eff_sub_d = c_eff_sub;
      s1_exp_d     = c_exp;
      s1_del_d     = c_del;
      s1_sig_a_d   = c_sig_a;
      s1_sig_b_d   = c_sig_b;
      s1_tag_d     = bus.in_tag;
    end

    // Illegal results already carry zero significands and exponent from stage 1.
    if (adv2 && s1_valid_q) begin
      o_nan_d     = s1_nan_q;
      o_inf_d     = s1_inf_q;
      o_legal_d   = ~s1_nan_q & ~s1_inf_q;
      o_sign_d    = s1_sign_q;
      o_eff_sub_d = s1_eff_sub_q;
      o_exp_d     = s1_exp_q;
      o_mant_a_d  = full_a;
      o_mant_b_d  = shift_b;
      o_tag_d     = s1_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_inf_q     <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_exp_q     <= '0;
      s1_del_q     <= '0;
      s1_sig_a_q   <= '0;
      s1_sig_b_q   <= '0;
      s1_tag_q     <= '0;
      o_nan_q      <= 1'b0;
      o_inf_q      <= 1'b0;
      o_legal_q    <= 1'b0;
      o_sign_q     <= 1'b0;
      o_eff_sub_q  <= 1'b0;
      o_exp_q      <= '0;
      o_mant_a_q   <= '0;
      o_mant_b_q   <= '0;
      o_tag_q      <= '0;
    end else begin
      rdy_q        <= rdy_d;
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      s1_nan_q     <= s1_nan_d;
      s1_inf_q     <= s1_inf_d;
      s1_sign_q    <= s1_sign_d;
      s1_eff_sub_q <= s1_eff_sub_d;
      s1_exp_q     <= s1_exp_d;
      s1_del_q     <= s1_del_d;
      s1_sig_a_q   <= s1_sig_a_d;
      s1_sig_b_q   <= s1_sig_b_d;
      s1_tag_q     <= s1_tag_d;
      o_nan_q      <= o_nan_d;
      o_inf_q      <= o_inf_d;
      o_legal_q    <= o_legal_d;
      o_sign_q     <= o_sign_d;
      o_eff_sub_q  <= o_eff_sub_d;
      o_exp_q      <= o_exp_d;
      o_mant_a_q   <= o_mant_a_d;
      o_mant_b_q   <= o_mant_b_d;
      o_tag_q      <= o_tag_d;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.nan_res   = o_nan_q;
  assign bus.inf_res   = o_inf_q;
  assign bus.legal     = o_legal_q;
  assign bus.res_sign  = o_sign_q;
  assign bus.eff_sub   = o_eff_sub_q;
  assign bus.exp_max   = o_exp_q;
  assign bus.mant_a    = o_mant_a_q;
  assign bus.mant_b    = o_mant_b_q;
  assign bus.out_tag   = o_tag_q;
endmodule

// File: tb/tb_fp_add_prep_pipe.sv
// Directed self-checking bench for fp_add_prep_pipe (FP32 parameters).
// Results are compared as one packed word {nan,inf,legal,sign,eff_sub,exp,mant_a,mant_b,tag}.
`timescale 1ns/1ps
module tb_fp_add_prep_pipe;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int TAG_W  = 4;
  localparam int MANT_W = 50;
  localparam int BODY_W = 5 + EXP_W + 2 * MANT_W;
  localparam int RES_W  = BODY_W + TAG_W;
  localparam logic [MANT_W-1:0] M47 = 50'h0_8000_0000_0000;
  localparam logic [MANT_W-1:0] M46 = 50'h0_4000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fp_add_prep_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();

  fp_add_prep_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0]       a;
    logic [31:0]       b;
    logic              sub;
    logic [BODY_W-1:0] body;
  } vec_t;
  vec_t vecs [16];

  function automatic logic [BODY_W-1:0] mk(input logic nan, input logic inf, input logic lg,
                                            input logic sg, input logic es, input logic [7:0] ex,
                                            input logic [MANT_W-1:0] ma, input logic [MANT_W-1:0] mb);
    return {nan, inf, lg, sg, es, ex, ma, mb};
  endfunction

  function automatic logic [RES_W-1:0] observe();
    return {bus.nan_res, bus.inf_res, bus.legal, bus.res_sign, bus.eff_sub,
            bus.exp_max, bus.mant_a, bus.mant_b, bus.out_tag};
  endfunction

  task automatic init_vecs();
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, mk(0,0,1,0,0,8'd127, M47, M47)};
    vecs[1]  = '{32'h3F800000, 32'h40000000, 1'b0, mk(0,0,1,0,0,8'd128, M47, M46)};
    vecs[2]  = '{32'h40000000, 32'h3F800000, 1'b0, mk(0,0,1,0,0,8'd128, M47, M46)};
    vecs[3]  = '{32'h3F800000, 32'h3F800000, 1'b1, mk(0,0,1,0,1,8'd127, M47, M47)};
    vecs[4]  = '{32'h3F800000, 32'h40000000, 1'b1, mk(0,0,1,1,1,8'd128, M47, M46)};
    vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, mk(1,0,0,0,1,8'd0, '0, '0)};
    vecs[6]  = '{32'hFF800000, 32'h3F800000, 1'b0, mk(0,1,0,1,1,8'd0, '0, '0)};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 1'b0, mk(1,0,0,0,0,8'd0, '0, '0)};
    vecs[8]  = '{32'h3F800000, 32'h0D800000, 1'b0, mk(0,0,1,0,0,8'd127, M47, 50'h1)};
    vecs[9]  = '{32'h3F800000, 32'h00000001, 1'b0, mk(0,0,1,0,0,8'd127, M47, 50'h1)};
    vecs[10] = '{32'h3F800000, 32'h00000000, 1'b0, mk(0,0,1,0,0,8'd127, M47, 50'h0)};
    vecs[11] = '{32'h3F800000, 32'h32800001, 1'b0, mk(0,0,1,0,0,8'd127, M47, 50'h20_0001)};
    vecs[12] = '{32'h3F800000, 32'h28800000, 1'b0, mk(0,0,1,0,0,8'd127, M47, 50'h2)};
    vecs[13] = '{32'h3F800000, 32'h27000000, 1'b0, mk(0,0,1,0,0,8'd127, M47, 50'h1)};
    vecs[14] = '{32'h80000000, 32'h80000000, 1'b0, mk(0,0,1,1,0,8'd1, '0, '0)};
    vecs[15] = '{32'h80000000, 32'h80000000, 1'b1, mk(0,0,1,0,1,8'd1, '0, '0)};
  endtask

  task automatic push(input int idx, input logic [3:0] tag);
    bus.op_1     = vecs[idx].a;
    bus.op_2     = vecs[idx].b;
    bus.op_sub   = vecs[idx].sub;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
  endtask

  // Presents one transaction, returns the result and cycles from presentation to out_valid.
  task automatic run_vec(input int idx, input logic [3:0] tag,
                         output logic [RES_W-1:0] res, output int lat);
    int w;
    push(idx, tag);
    #1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = observe();
    $display("[TB] vec %0d op_1=%h op_2=%h sub=%0d tag=%0d -> lat=%0d res=%h",
             idx, vecs[idx].a, vecs[idx].b, vecs[idx].sub, tag, lat, res);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.op_1 = '0; bus.op_2 = '0; bus.op_sub = 1'b0;
    bus.in_tag = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL reset_handshake in_ready=%b out_valid=%b required 0 0", bus.in_ready, bus.out_valid);
    else if (0) tests_failed++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) tests_failed++;
    tests_run++;
    if (observe() !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h required 0", observe());
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_basic();
    logic [RES_W-1:0] r;
    int lat;
    for (int i = 0; i <= 4; i++) begin
      run_vec(i, 4'(i + 1), r, lat);
      tests_run++;
      if (lat !== 2) begin
        tests_failed++;
        $display("FAIL basic_latency[%0d] got=%0d required 2", i, lat);
      end
      tests_run++;
      if (r !== {vecs[i].body, 4'(i + 1)}) begin
        tests_failed++;
        $display("FAIL basic_result[%0d] got=%h required %h", i, r, {vecs[i].body, 4'(i + 1)});
      end
    end
  endtask

  task automatic test_special();
    logic [RES_W-1:0] r;
    int idx [5] = '{5, 6, 7, 14, 15};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_vec(idx[i], 4'(idx[i]), r, lat);
      tests_run++;
      if (r !== {vecs[idx[i]].body, 4'(idx[i])}) begin
        tests_failed++;
        $display("FAIL special_result[%0d] got=%h required %h", idx[i], r, {vecs[idx[i]].body, 4'(idx[i])});
      end
    end
  endtask

  task automatic test_align();
    logic [RES_W-1:0] r;
    int lat;
    for (int i = 8; i <= 13; i++) begin
      run_vec(i, 4'(i), r, lat);
      tests_run++;
      if (r !== {vecs[i].body, 4'(i)}) begin
        tests_failed++;
        $display("FAIL align_result[%0d] got=%h required %h", i, r, {vecs[i].body, 4'(i)});
      end
    end
  endtask

  task automatic test_back_to_back();
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    logic [RES_W-1:0] held = '0;
    logic held_v = 1'b0;
    while (popped < 6 && cyc < 40) begin
      bus.out_ready = (cyc >= 2 && cyc <= 5) ? 1'b0 : 1'b1;
      if (pushed < 6) push(pushed, 4'(pushed + 1));
      else bus.in_valid = 1'b0;
      #1;
      if (cyc == 2) begin
        tests_run++;
        if (bus.in_ready !== 1'b0 || pushed !== 2) begin
          tests_failed++;
          $display("FAIL b2b_stall_ready in_ready=%b accepted=%0d required 0 2", bus.in_ready, pushed);
        end
      end
      if (held_v && bus.out_valid) begin
        tests_run++;
        if (observe() !== held) begin
          tests_failed++;
          $display("FAIL b2b_stable got=%h required %h", observe(), held);
        end
      end
      held_v = bus.out_valid && !bus.out_ready;
      held   = observe();
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (observe() !== {vecs[popped].body, 4'(popped + 1)}) begin
          tests_failed++;
          $display("FAIL b2b_result[%0d] got=%h required %h", popped, observe(),
                   {vecs[popped].body, 4'(popped + 1)});
        end
        $display("[TB] b2b pop %0d tag=%0d res=%h", popped, bus.out_tag, observe());
        popped++;
      end
      if (bus.in_valid && bus.in_ready) pushed++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tests_run++;
    if (popped !== 6) begin
      tests_failed++;
      $display("FAIL b2b_count got=%0d required 6", popped);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_no_extra out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    logic [RES_W-1:0] r;
    int lat;
    int seen = 0;
    bus.out_ready = 1'b0;
    push(0, 4'd7); @(posedge clk); #1;
    push(1, 4'd8); @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_inflight out_valid=%b required 1", bus.out_valid);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    push(2, 4'd9);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clear in_ready=%b out_valid=%b required 0 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL flush_leak results=%0d required 0", seen);
    end
    $display("[TB] flush done, leaked=%0d", seen);
    run_vec(3, 4'd10, r, lat);
    tests_run++;
    if (lat !== 2 || r !== {vecs[3].body, 4'd10}) begin
      tests_failed++;
      $display("FAIL flush_after lat=%0d got=%h required 2 %h", lat, r, {vecs[3].body, 4'd10});
    end
  endtask

  task automatic test_async_reset();
    logic [RES_W-1:0] r;
    int lat;
    int seen = 0;
    bus.out_ready = 1'b0;
    push(1, 4'd3); @(posedge clk); #1;
    push(4, 4'd4); @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || observe() !== '0) begin
      tests_failed++;
      $display("FAIL async_reset out_valid=%b in_ready=%b outs=%h required 0 0 0",
               bus.out_valid, bus.in_ready, observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset_after results=%0d in_ready=%b required 0 1", seen, bus.in_ready);
    end
    $display("[TB] async reset done, leaked=%0d", seen);
    run_vec(2, 4'd12, r, lat);
    tests_run++;
    if (lat !== 2 || r !== {vecs[2].body, 4'd12}) begin
      tests_failed++;
      $display("FAIL async_reset_resume lat=%0d got=%h required 2 %h", lat, r, {vecs[2].body, 4'd12});
    end
  endtask

  initial begin
    init_vecs();
    test_reset();
    test_basic();
    test_special();
    test_align();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
